// File: rtl/buffer_quadro_if.sv
// Write port of the frame store: row writes with valid/ready handshake and frame commit.
interface buffer_quadro_if;
  logic       escritaValida;
  logic       escritaPronta;
  logic [2:0] endereco;
  logic [4:0] dado;
  logic       ultima;

  modport master (
    output escritaValida, endereco, dado, ultima,
    input  escritaPronta
  );

  modport slave (
    input  escritaValida, endereco, dado, ultima,
    output escritaPronta
  );
endinterface

// File: rtl/buffer_quadro.sv
// Double-buffered 7x5 frame store; back buffer swaps into the front on the frame tick after a commit.
// Optional blink (macro BUFFER_QUADRO_PISCA_EN) blanks the rows every TICKS_PISCA frame ticks.
module buffer_quadro #(
  parameter int TICKS_PISCA = 16
) (
  input  logic           clock,
  input  logic           resetN,
  buffer_quadro_if.slave escrita,
  input  logic           quadroTick,
  input  logic           pisca,
  output logic [4:0]     linha0,
  output logic [4:0]     linha1,
  output logic [4:0]     linha2,
  output logic [4:0]     linha3,
  output logic [4:0]     linha4,
  output logic [4:0]     linha5,
  output logic [4:0]     linha6,
  output logic           erroEndereco
);

  typedef enum logic {LIVRE = 1'b0, PENDENTE = 1'b1} estado_t;

  estado_t         estado_q, estado_d;
  logic [6:0][4:0] back_q, back_d;
  logic [6:0][4:0] front_q, front_d;
  logic            erro_q, erro_d;
  logic            aceita;
  logic            apaga;

  assign escrita.escritaPronta = (estado_q == LIVRE) && resetN;
  assign aceita = escrita.escritaValida && escrita.escritaPronta;

  always_comb begin
    estado_d = estado_q;
    back_d   = back_q;
    front_d  = front_q;
    erro_d   = erro_q;
    case (estado_q)
      LIVRE: begin
        if (aceita && escrita.ultima) estado_d = PENDENTE;
      end
      PENDENTE: begin
        // Whole frame moves at once so the scan never sees a mix of old and new rows.
        if (quadroTick) begin
          front_d  = back_q;
          estado_d = LIVRE;
        end
      end
      default: estado_d = LIVRE;
    endcase
    if (aceita) begin
      if (escrita.endereco == 3'd7) erro_d = 1'b1;
      else back_d[escrita.endereco] = escrita.dado;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      estado_q <= LIVRE;
      back_q   <= '0;
      front_q  <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      back_q   <= back_d;
      front_q  <= front_d;
      erro_q   <= erro_d;
    end
  end

`ifdef BUFFER_QUADRO_PISCA_EN
  logic [7:0] cont_q, cont_d;
  logic       fase_q, fase_d;

  always_comb begin
    cont_d = cont_q;
    fase_d = fase_q;
    if (quadroTick) begin
      if (cont_q == 8'(TICKS_PISCA - 1)) begin
        cont_d = '0;
        fase_d = ~fase_q;
      end else begin
        cont_d = cont_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      cont_q <= '0;
      fase_q <= 1'b0;
    end else begin
      cont_q <= cont_d;
      fase_q <= fase_d;
    end
  end

  assign apaga = pisca && fase_q;
`else
  logic unused_cfg;
  assign unused_cfg = pisca ^ TICKS_PISCA[0];
  assign apaga = 1'b0;
`endif

  // Blanking only masks the outputs; the stored frame survives the dark phase.
  assign linha0 = apaga ? 5'd0 : front_q[0];
  assign linha1 = apaga ? 5'd0 : front_q[1];
  assign linha2 = apaga ? 5'd0 : front_q[2];
  assign linha3 = apaga ? 5'd0 : front_q[3];
  assign linha4 = apaga ? 5'd0 : front_q[4];
  assign linha5 = apaga ? 5'd0 : front_q[5];
  assign linha6 = apaga ? 5'd0 : front_q[6];

  assign erroEndereco = erro_q;

endmodule

// File: tb/tb_buffer_quadro.sv
// Randomized + directed scoreboard bench for buffer_quadro against a frame-level reference model.
module tb_buffer_quadro;
  localparam int T = 4;
`ifdef BUFFER_QUADRO_PISCA_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetN;
  logic       quadroTick;
  logic       pisca;
  logic [4:0] linha0, linha1, linha2, linha3, linha4, linha5, linha6;
  logic       erroEndereco;

  buffer_quadro_if bus();

  buffer_quadro #(.TICKS_PISCA(T)) dut (
    .clock        (clock),
    .resetN       (resetN),
    .escrita      (bus),
    .quadroTick   (quadroTick),
    .pisca        (pisca),
    .linha0       (linha0),
    .linha1       (linha1),
    .linha2       (linha2),
    .linha3       (linha3),
    .linha4       (linha4),
    .linha5       (linha5),
    .linha6       (linha6),
    .erroEndereco (erroEndereco)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [34:0] rows;
    logic        pronta;
    logic        erro;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   cur_pi = 1'b0;

  // Reference model: the two frames as arrays plus a pending-commit flag.
  logic [4:0] m_back[7];
  logic [4:0] m_front[7];
  bit         m_pend, m_err, m_phase;
  int         m_cnt;

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rows", {linha6, linha5, linha4, linha3, linha2, linha1, linha0}, e.rows);
      chk("pronta", {34'd0, bus.escritaPronta}, {34'd0, e.pronta});
      chk("erro", {34'd0, erroEndereco}, {34'd0, e.erro});
    end
  end

  task automatic step(input bit rn, input bit v, input logic [2:0] a, input logic [4:0] d,
                      input bit u, input bit tk, input bit pi);
    exp_t e;
    bit   acc;
    @(negedge clock);
    #1;
    resetN = rn; bus.escritaValida = v; bus.endereco = a; bus.dado = d;
    bus.ultima = u; quadroTick = tk; pisca = pi;
    if (!rn) begin
      for (int i = 0; i < 7; i++) begin m_back[i] = '0; m_front[i] = '0; end
      m_pend = 0; m_err = 0; m_phase = 0; m_cnt = 0;
    end else begin
      acc = v && !m_pend;
      if (m_pend && tk) begin
        m_front = m_back;
        m_pend = 0;
      end
      if (acc) begin
        if (a == 3'd7) m_err = 1;
        else m_back[a] = d;
        if (u) m_pend = 1;
      end
      if (tk) begin
        m_cnt++;
        if (m_cnt == T) begin m_cnt = 0; m_phase = !m_phase; end
      end
    end
    e.pronta = rn && !m_pend;
    e.erro   = m_err;
    e.rows   = '0;
    if (!(BLINK && pi && m_phase))
      for (int i = 0; i < 7; i++) e.rows[i*5 +: 5] = m_front[i];
    @(posedge clock);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 3'd0, 5'd0, 0, 0, cur_pi);
  endtask

  task automatic tick();
    step(1, 0, 3'd0, 5'd0, 0, 1, cur_pi);
  endtask

  initial begin
    logic [4:0] pats[7];
    pats = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F, 5'h15};
    resetN = 0; bus.escritaValida = 0; bus.endereco = 0; bus.dado = 0;
    bus.ultima = 0; quadroTick = 0; pisca = 0;

    step(0, 0, 3'd0, 5'd0, 0, 0, 0);
    step(0, 0, 3'd0, 5'd0, 0, 0, 0);
    idle(10);

    // Full frame, held back until the tick
    for (int r = 0; r < 7; r++) step(1, 1, 3'(r), pats[r], r == 6, 0, 0);
    idle(3);
    tick();
    idle(2);

    // Stall while pending: row 2 write waits for the swap
    step(1, 1, 3'd0, 5'h03, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 3'd2, 5'h1F, 0, 0, 0);
    step(1, 1, 3'd2, 5'h1F, 0, 1, 0);
    step(1, 1, 3'd2, 5'h1F, 0, 0, 0);
    idle(3);

    // Bad address, then a commit through address 7
    step(1, 1, 3'd7, 5'h1F, 0, 0, 0);
    idle(2);
    step(1, 1, 3'd7, 5'h0A, 1, 1, 0);
    idle(2);
    tick();
    idle(2);
    step(0, 0, 3'd0, 5'd0, 0, 0, 0);
    idle(2);

    // Reset while pending abandons the swap
    step(1, 1, 3'd1, 5'h0A, 1, 0, 0);
    step(0, 0, 3'd0, 5'd0, 0, 0, 0);
    tick();
    idle(2);

    // Blink
    cur_pi = 1;
    for (int r = 0; r < 7; r++) step(1, 1, 3'(r), pats[6-r], r == 6, 0, 1);
    tick();
    for (int i = 0; i < 20; i++) begin tick(); idle(1); end
    cur_pi = 0;
    idle(2);

    for (int i = 0; i < 1500; i++)
      step(($urandom % 100) != 0, $urandom % 2, 3'($urandom % 8), 5'($urandom % 32),
           ($urandom % 4) == 0, ($urandom % 6) == 0, $urandom % 2);

    idle(2);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
